// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: processes a WIDTH-bit operand pair DIGIT bits per cycle
// through one narrow adder slice, with carry/overflow/zero flags and a start/busy/done handshake.
module serial_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic [DIGIT:0]     sum;
    logic               msb_cin;
    logic               last_digit;

    // One DIGIT-bit slice add; bit DIGIT is the slice carry-out.
    assign sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};

    // Carry into the slice MSB recovered from the sum bit; on the last digit this is bit WIDTH-1.
    assign msb_cin    = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ sum[DIGIT-1];
    assign last_digit = (cnt_q == CNT_W'(N - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = (acc_q >> DIGIT) | (WIDTH'(sum[DIGIT-1:0]) << (WIDTH - DIGIT));
                carry_d = sum[DIGIT];
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_digit) begin
                    // Result and flags are published only here, so they hold during RUN.
                    cnt_d   = '0;
                    r_d     = acc_d;
                    cout_d  = sum[DIGIT];
                    ovf_d   = msb_cin ^ sum[DIGIT];
                    zero_d  = (acc_d == '0);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign r    = r_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three configurations (8/4, 16/1, 8/8) checked against
// directed vectors and an arithmetic reference model.
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  st;
    logic        sub_in, cin_in;
    logic [15:0] a_in, b_in;

    logic        busy0, done0, cout0, ovf0, zero0;
    logic [7:0]  r0;
    logic        busy1, done1, cout1, ovf1, zero1;
    logic [15:0] r1;
    logic        busy2, done2, cout2, ovf2, zero2;
    logic [7:0]  r2;

    int          sel_m;
    logic        busy_m, done_m, cout_m, ovf_m, zero_m;
    logic [15:0] r_m;
    logic [15:0] held [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .DIGIT(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sub_in), .cin(cin_in),
        .a(a_in[7:0]), .b(b_in[7:0]), .busy(busy0), .done(done0), .r(r0),
        .cout(cout0), .ovf(ovf0), .zero(zero0));

    serial_addsub #(.WIDTH(16), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sub_in), .cin(cin_in),
        .a(a_in), .b(b_in), .busy(busy1), .done(done1), .r(r1),
        .cout(cout1), .ovf(ovf1), .zero(zero1));

    serial_addsub #(.WIDTH(8), .DIGIT(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sub_in), .cin(cin_in),
        .a(a_in[7:0]), .b(b_in[7:0]), .busy(busy2), .done(done2), .r(r2),
        .cout(cout2), .ovf(ovf2), .zero(zero2));

    always_comb begin
        busy_m = busy0; done_m = done0; r_m = {8'h00, r0};
        cout_m = cout0; ovf_m = ovf0;   zero_m = zero0;
        if (sel_m == 1) begin
            busy_m = busy1; done_m = done1; r_m = r1;
            cout_m = cout1; ovf_m = ovf1;   zero_m = zero1;
        end else if (sel_m == 2) begin
            busy_m = busy2; done_m = done2; r_m = {8'h00, r2};
            cout_m = cout2; ovf_m = ovf2;   zero_m = zero2;
        end
    end

    function automatic int width_of(input int sel);
        return (sel == 1) ? 16 : 8;
    endfunction

    function automatic int digits_of(input int sel);
        return (sel == 0) ? 2 : ((sel == 1) ? 16 : 1);
    endfunction

    // Reference: plain unsigned/signed integer arithmetic on WIDTH-bit operands.
    task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic c,
                         output logic [15:0] er, output logic eco, output logic eov,
                         output logic ez);
        int mask, half, ua, ub, full, sa, sb, ss;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        ua   = int'(a) & mask;
        ub   = int'(b) & mask;
        full = s ? (ua - ub - int'(c)) : (ua + ub + int'(c));
        er   = 16'(full & mask);
        eco  = s ? (ua >= ub + int'(c)) : (full > mask);
        sa   = (ua >= half) ? ua - (1 << w) : ua;
        sb   = (ub >= half) ? ub - (1 << w) : ub;
        ss   = s ? (sa - sb - int'(c)) : (sa + sb + int'(c));
        eov  = (ss < -half) || (ss > half - 1);
        ez   = (er == 16'h0000);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one operation on DUT sel and check it through its done cycle.
    // Returns #1 after the edge that raises done, so a caller may start back-to-back.
    task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic c, input logic [15:0] er,
                         input logic eco, input logic eov, input logic ez,
                         input bit pulse_in_run);
        int cyc;
        bit bad;
        sel_m = sel;
        a_in = a; b_in = b; sub_in = s; cin_in = c;
        st = '0;
        st[sel] = 1'b1;
        @(posedge clk); #1;
        st = '0;
        a_in = 16'($urandom); b_in = 16'($urandom);
        sub_in = 1'($urandom); cin_in = 1'($urandom);
        chk("busy_after_start", 32'(busy_m), 32'd1);
        chk("done_low_after_start", 32'(done_m), 32'd0);
        cyc = 0;
        bad = 1'b0;
        while (done_m !== 1'b1 && cyc < 40) begin
            if (busy_m !== 1'b1 || r_m !== held[sel]) bad = 1'b1;
            if (pulse_in_run && cyc == 0) begin
                st[sel] = 1'b1;
                a_in = ~a; b_in = ~b; sub_in = ~s;
            end
            @(posedge clk); #1;
            st = '0;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(digits_of(sel)));
        chk("busy_and_hold_during_run", 32'(bad), 32'd0);
        chk("done_pulse", 32'(done_m), 32'd1);
        chk("busy_low_in_done", 32'(busy_m), 32'd0);
        chk("r", 32'(r_m), 32'(er));
        chk("cout", 32'(cout_m), 32'(eco));
        chk("ovf", 32'(ovf_m), 32'(eov));
        chk("zero", 32'(zero_m), 32'(ez));
        held[sel] = er;
    endtask

    task automatic idle_after_done();
        @(posedge clk); #1;
        chk("done_single_cycle", 32'(done_m), 32'd0);
        chk("busy_idle", 32'(busy_m), 32'd0);
    endtask

    typedef struct {
        int          sel;
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic        c;
        logic [15:0] er;
        logic        eco;
        logic        eov;
        logic        ez;
    } vec_t;

    initial begin
        vec_t        vecs [12];
        logic [15:0] er, ra, rb;
        logic        eco, eov, ez, rs, rc;
        bit          seen_done;
        int          sel;

        vecs[0]  = '{0, 16'h003C, 16'h005A, 1'b0, 1'b0, 16'h0096, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{0, 16'h0010, 16'h0020, 1'b1, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{0, 16'h0080, 16'h0001, 1'b1, 1'b0, 16'h007F, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{0, 16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{0, 16'h007F, 16'h0000, 1'b0, 1'b1, 16'h0080, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{2, 16'h003C, 16'h005A, 1'b0, 1'b0, 16'h0096, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{2, 16'h0010, 16'h0020, 1'b1, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        st = '0; sub_in = 1'b0; cin_in = 1'b0; a_in = '0; b_in = '0;
        sel_m = 0;
        for (int i = 0; i < 3; i++) held[i] = 16'h0000;

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            sel_m = i;
            #1;
            chk("reset_state", {26'd0, busy_m, done_m, cout_m, ovf_m, zero_m, |r_m},
                {26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c,
                  vecs[i].er, vecs[i].eco, vecs[i].eov, vecs[i].ez, 1'b0);
            idle_after_done();
        end

        // Start during RUN is ignored: first result stands, only one done pulse.
        do_op(0, 16'h0021, 16'h0011, 1'b0, 1'b0, 16'h0032, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_after_done();

        // Start in the done cycle: second op follows immediately.
        do_op(0, 16'h0040, 16'h0040, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op(0, 16'h0003, 16'h0004, 1'b1, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_after_done();

        // Reset one cycle into a run aborts without a done pulse.
        sel_m = 0;
        a_in = 16'h0012; b_in = 16'h0034; sub_in = 1'b0; cin_in = 1'b0;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st = '0;
        chk("busy_before_abort", 32'(busy_m), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy_m), 32'd0);
        chk("abort_r", 32'(r_m), 32'd0);
        chk("abort_zero", 32'(zero_m), 32'd1);
        seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done_m === 1'b1) seen_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) held[i] = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done_m === 1'b1) seen_done = 1'b1;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        do_op(0, 16'h0012, 16'h0034, 1'b0, 1'b0, 16'h0046, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_after_done();

        // Randomized operations across all three configurations.
        for (int i = 0; i < 36; i++) begin
            sel = i % 3;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            rc = 1'($urandom);
            if (width_of(sel) == 8) begin
                ra[15:8] = 8'h00;
                rb[15:8] = 8'h00;
            end
            model(width_of(sel), ra, rb, rs, rc, er, eco, eov, ez);
            do_op(sel, ra, rb, rs, rc, er, eco, eov, ez, 1'b0);
            if ($urandom_range(0, 1) == 1) idle_after_done();
        end
        idle_after_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
